// File: rtl/md_ctrl_pkg.sv
// Shared constants for the multiply/divide sequencing controller:
// SPECIAL opcode, HI/LO funct codes, unit operation and HI/LO write encodings.
package md_ctrl_pkg;

  localparam logic [5:0] SPECIAL     = 6'b000000;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // Operation code driven to the unit; equals funct[1:0] of the START class.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] HILOWR_NONE = 2'b00;
  localparam logic [1:0] HILOWR_HI   = 2'b01;
  localparam logic [1:0] HILOWR_LO   = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_decode.sv
// Combinational classifier for HI/LO-class instructions.
// op carries funct[1:0]: the unit operation for START, and bit 1 picks
// HI (0) versus LO (1) for the WRITE and READ classes.
module md_decode
  import md_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_start,
  output logic        is_write,
  output logic        is_read,
  output logic [1:0]  op
);

  logic       special;
  logic [5:0] funct;
  // rs/rt/rd/shamt play no part in the classification
  logic       unused_fields;

  assign special       = (instr[31:26] == SPECIAL);
  assign funct         = instr[5:0];
  assign op            = funct[1:0];
  assign unused_fields = ^instr[25:6];

  // Classify by funct once the opcode is known to be SPECIAL
  always_comb begin
    is_start = 1'b0;
    is_write = 1'b0;
    is_read  = 1'b0;
    if (special) begin
      case (funct)
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_start = 1'b1;
        FUNCT_MTHI, FUNCT_MTLO:                         is_write = 1'b1;
        FUNCT_MFHI, FUNCT_MFLO:                         is_read  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencing controller for the E stage. Issues start and
// HI/LO write strobes, counts the unit's fixed latency, and stalls D for any
// HI/LO-class instruction that would collide with an operation in flight.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic        valid_E,
  input  logic        flush_E,
  input  logic [31:0] srcB_E,
  input  logic        md_stall_in,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [1:0]  md_hilowr,
  output logic        busy,
  output logic        stall_D,
  output logic        md_done,
  output logic        div0
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_t  state;
  logic [3:0] cnt;
  logic       done_q;
  logic       div0_q;

  logic       e_start, e_write, e_read_unused;
  logic [1:0] e_op;
  logic       d_start, d_write, d_read;
  logic [1:0] d_op_unused;
  logic       issue_ok;

  md_decode u_dec_e (
    .instr    (instr_E),
    .is_start (e_start),
    .is_write (e_write),
    .is_read  (e_read_unused),
    .op       (e_op)
  );

  md_decode u_dec_d (
    .instr    (instr_D),
    .is_start (d_start),
    .is_write (d_write),
    .is_read  (d_read),
    .op       (d_op_unused)
  );

  // An out-of-sync busy flag from the unit blocks issue even while IDLE
  assign issue_ok  = valid_E & ~flush_E & (state == ST_IDLE) & ~md_stall_in;
  assign md_start  = issue_ok & e_start;
  assign md_op     = md_start ? e_op : MD_MULT;
  assign md_hilowr = (issue_ok & e_write) ? (e_op[1] ? HILOWR_LO : HILOWR_HI)
                                          : HILOWR_NONE;
  assign busy      = (state == ST_BUSY) | md_stall_in;
  // Stall already in the start cycle so a dependent HI/LO op never slips in
  assign stall_D   = (d_start | d_write | d_read) & (busy | md_start);
  assign md_done   = done_q;
  assign div0      = div0_q;

  // Latency sequencer; done_q is pre-computed so it is high in the cnt==1 cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (md_start) begin
            state  <= ST_BUSY;
            div0_q <= e_op[1] & (srcB_E == 32'd0);
            if (e_op[1]) begin
              cnt    <= DIV_CNT;
              done_q <= (DIV_CNT == 4'd1);
            end else begin
              cnt    <= MULT_CNT;
              done_q <= (MULT_CNT == 4'd1);
            end
          end
        end
        ST_BUSY: begin
          if (cnt <= 4'd1) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            done_q <= 1'b0;
          end else begin
            cnt    <= cnt - 4'd1;
            done_q <= (cnt == 4'd2);
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= 4'd0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the multiply/divide unit in the E stage of the five-stage MIPS pipeline. Decodes the E-stage instruction and drives the unit's start, operation and HI/LO write controls. Tracks the unit's fixed multi-cycle latency with its own state machine and raises the D-stage stall for any HI/LO-class instruction that would otherwise collide with an operation in flight.

## Interface
Parameters:
- MULT_LAT, 5, cycles from the start edge until HI/LO hold the mult/multu result
- DIV_LAT, 10, cycles from the start edge until HI/LO hold the div/divu result (4-bit counter, both ≤ 15)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr_D  in  32  instruction in D stage
- instr_E  in  32  instruction in E stage
- valid_E  in  1  instr_E is a live (non-bubble) instruction
- flush_E  in  1  E-stage instruction is being cancelled this cycle
- srcB_E  in  32  E-stage divisor operand (zero check only)
- md_stall_in  in  1  unit's own busy flag, OR-ed into busy
- md_start  out  1  start strobe to the unit (combinational)
- md_op  out  2  00 mult, 01 multu, 10 div, 11 divu (combinational, valid with md_start)
- md_hilowr  out  2  01 mthi, 10 mtlo, 00 none (combinational)
- busy  out  1  operation in flight
- stall_D  out  1  hold D stage
- md_done  out  1  one-cycle pulse when the operation completes
- div0  out  1  last started operation was a divide by zero; sticky until the next start

## Operation
- Decode: opcode 000000 with funct mult 011000, multu 011001, div 011010, divu 011011 (START class); mthi 010001, mtlo 010011 (WRITE class); mfhi 010000, mflo 010010 (READ class). HI/LO-class = START ∪ WRITE ∪ READ.
- issue_ok = valid_E & ~flush_E & (state==IDLE) & ~md_stall_in.
- md_start = issue_ok & instr_E in START. md_op = funct[1:0].
- md_hilowr = 01 for mthi / 10 for mtlo when issue_ok; otherwise 00. Never asserted together with md_start.
- FSM states are IDLE and BUSY:
  - IDLE→BUSY on md_start. cnt loads MULT_LAT or DIV_LAT. div0 loads (funct is div/divu) & (srcB_E==0).
  - BUSY: cnt decrements each edge. At an edge with cnt==1: go to IDLE, cnt←0, md_done←1 for one cycle.
  - Divide by zero still occupies the full DIV_LAT. The unit leaves HI/LO unchanged; the controller only flags div0.
- busy = (state==BUSY) | md_stall_in.
- stall_D = instr_D in HI/LO-class & (busy | md_start).
- flush_E in the start cycle: no start, no state change. A flush during BUSY does not abort; the operation completes.

## Timing
- Reset values: state IDLE, cnt 0, busy 0 (absent md_stall_in), md_done 0, div0 0. Combinational outputs are 0 when instr_E is a non-HI/LO instruction.
- Latency: start sampled at edge N. busy stays high over cycles N+1 … N+LAT. Return to IDLE and md_done occur at edge N+LAT. A READ-class instruction in D issues at the earliest in the cycle after N+LAT.
- Back-to-back: a second START in D while the first is in E stalls from cycle N (md_start high) until busy falls.
- Reset mid-BUSY: immediate return to IDLE, no md_done. The unit is reset by the same signal.
- md_stall_in high while state==IDLE (unit out of sync): issue is blocked until it falls. This is not an error.

## Structure
- Shared package: funct constants (FUNCT_MULT … FUNCT_MTLO), the md_op encoding, the md_hilowr encoding, and the opcode SPECIAL = 6'b000000.
- One sub-module: md_decode, a pure combinational classifier (instr → is_start, is_write, is_read, op). It is instantiated twice, once for D and once for E.

## Test plan
- mult at E with valid_E=1 in cycle 0 → md_start=1, md_op=00 in cycle 0; busy=1 in cycles 1–5; md_done=1 in cycle 5; state IDLE after edge 5.
- divu with srcB_E=0 → md_op=11, div0=1 from cycle 1; busy for 10 cycles; div0 stays 1 until the next start.
- mfhi in D while div is busy (cnt=7) → stall_D=1 for 7 cycles; stall_D=0 in the first cycle after md_done.
- mthi at E while IDLE → md_hilowr=01, md_start=0, no state change. mult in D simultaneously → stall_D=0.
- mult at E with flush_E=1 → md_start=0, busy stays 0. The same instruction re-presented with flush_E=0 → normal issue.
- Reset asserted asynchronously at cnt=3 of a mult → busy=0 and state IDLE before the next edge; no md_done pulse; a following div issues normally.
